// File: rtl/bat_register_file.sv
// Eight-register file with a shared read/write bus, per-register increment and an
// output queue fed by reg 7. Define BAT_OUT_FIFO_EN for a 4-deep queue (default depth 1).
module bat_register_file #(
  parameter int DATA_W = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [7:0]        REGS_INC,
  input  logic [7:0]        REGS_RW,
  input  logic [7:0]        REGS_EN,
  input  logic [DATA_W-1:0] BUS_IN,
  output logic [DATA_W-1:0] BUS_OUT,
  output logic              BUS_DRIVE,
  output logic [DATA_W-1:0] REG_A,
  output logic [DATA_W-1:0] REG_B,
  output logic [DATA_W-1:0] OUT_DATA,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic              BUS_CONFLICT,
  output logic              OUT_OVERFLOW
);

  localparam int NREGS = 8;
`ifdef BAT_OUT_FIFO_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 1;
`endif
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  function automatic logic [DATA_W-1:0] wrap_inc(input logic [DATA_W-1:0] v);
    return v + DATA_W'(1);
  endfunction

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) return '0;
    return p + PTR_W'(1);
  endfunction

  logic [DATA_W-1:0] regs [NREGS];
  logic [NREGS-1:0]  rd_sel;
  logic [NREGS-1:0]  wr_sel;
  logic [NREGS-1:0]  inc_sel;
  logic              multi_rd;

  assign rd_sel   = REGS_EN & REGS_RW;
  assign wr_sel   = REGS_EN & ~REGS_RW;
  assign inc_sel  = REGS_INC & ~REGS_RW & ~REGS_EN;
  // Clearing the lowest set bit leaves something only if two or more readers exist.
  assign multi_rd = |(rd_sel & (rd_sel - NREGS'(1)));

  assign REG_A = regs[0];
  assign REG_B = regs[1];

  // Read path: lowest-index reader wins the bus.
  always_comb begin
    BUS_OUT   = '0;
    BUS_DRIVE = 1'b0;
    for (int i = NREGS - 1; i >= 0; i--) begin
      if (rd_sel[i]) begin
        BUS_OUT   = regs[i];
        BUS_DRIVE = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (wr_sel[i])       regs[i] <= BUS_IN;
        else if (inc_sel[i]) regs[i] <= wrap_inc(regs[i]);
      end
    end
  end

  // Output queue: every reg 7 update pushes its new value.
  logic [DATA_W-1:0] fifo_mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;
  logic [DATA_W-1:0] reg7_next;
  logic              push;
  logic              pop;
  logic              full;
  logic              push_ok;

  assign reg7_next = wr_sel[7] ? BUS_IN : wrap_inc(regs[7]);
  assign push      = wr_sel[7] | inc_sel[7];
  assign OUT_VALID = (count != '0);
  assign full      = (count == CNT_W'(DEPTH));
  assign pop       = OUT_VALID & OUT_READY;
  assign push_ok   = push & (~full | pop);
  assign OUT_DATA  = OUT_VALID ? fifo_mem[rd_ptr] : '0;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      BUS_CONFLICT <= 1'b0;
      OUT_OVERFLOW <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= ptr_next(wr_ptr);
      if (pop)     rd_ptr <= ptr_next(rd_ptr);
      if (push_ok && !pop)      count <= count + CNT_W'(1);
      else if (!push_ok && pop) count <= count - CNT_W'(1);
      if (push && !push_ok) OUT_OVERFLOW <= 1'b1;
      if (multi_rd)         BUS_CONFLICT <= 1'b1;
    end
  end

  // Queue storage carries data only; validity comes from count.
  always_ff @(posedge CLK) begin
    if (RST && push_ok) fifo_mem[wr_ptr] <= reg7_next;
  end

endmodule

// File: tb/tb_bat_register_file.sv
// Randomized + directed bench for bat_register_file with a queue-based scoreboard.
module tb_bat_register_file;
`ifdef BAT_OUT_FIFO_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 1;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] regs_inc = '0, regs_rw = '0, regs_en = '0, bus_in = '0;
  logic [7:0] bus_out, reg_a, reg_b, out_data;
  logic       bus_drive, out_valid, out_ready = 1'b0, bus_conflict, out_overflow;

  bat_register_file dut (
    .CLK(clk), .RST(rst), .REGS_INC(regs_inc), .REGS_RW(regs_rw), .REGS_EN(regs_en),
    .BUS_IN(bus_in), .BUS_OUT(bus_out), .BUS_DRIVE(bus_drive), .REG_A(reg_a),
    .REG_B(reg_b), .OUT_DATA(out_data), .OUT_VALID(out_valid), .OUT_READY(out_ready),
    .BUS_CONFLICT(bus_conflict), .OUT_OVERFLOW(out_overflow)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] m_regs [8];
  logic [7:0] exp_q [$];
  int         occ = 0;
  bit         m_conf = 0, m_ovf = 0, started = 0, last_rst = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: applies one clock edge's worth of the register-file rules.
  task automatic model_step(input logic [7:0] inc, rw, en, bus, input logic rdy, rstn);
    bit popped, upd7;
    int occ_before;
    if (!rstn) begin
      for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
      occ = 0; exp_q.delete(); m_conf = 0; m_ovf = 0; last_rst = 1;
      return;
    end
    last_rst   = 0;
    occ_before = occ;
    popped     = (occ_before > 0) && rdy;
    if ($countones(en & rw) > 1) m_conf = 1;
    upd7 = 0;
    for (int i = 0; i < 8; i++) begin
      if (en[i] && !rw[i]) begin
        m_regs[i] = bus;
        if (i == 7) upd7 = 1;
      end else if (inc[i] && !rw[i] && !en[i]) begin
        m_regs[i] = 8'((int'(m_regs[i]) + 1) % 256);
        if (i == 7) upd7 = 1;
      end
    end
    if (popped) occ--;
    if (upd7) begin
      if (occ_before < DEPTH || popped) begin
        exp_q.push_back(m_regs[7]);
        occ++;
      end else m_ovf = 1;
    end
  endtask

  task automatic drive(input logic [7:0] inc, rw, en, bus, input logic rdy, rstn);
    logic [7:0] eb;
    logic       ed;
    @(negedge clk);
    regs_inc = inc; regs_rw = rw; regs_en = en; bus_in = bus; out_ready = rdy; rst = rstn;
    #1;
    if (started) begin
      eb = 8'h00; ed = 1'b0;
      for (int i = 0; i < 8; i++)
        if (!ed && en[i] && rw[i]) begin eb = m_regs[i]; ed = 1'b1; end
      check("bus_out", 32'(bus_out), 32'(eb));
      check("bus_drive", 32'(bus_drive), 32'(ed));
      check("reg_a", 32'(reg_a), 32'(m_regs[0]));
      check("reg_b", 32'(reg_b), 32'(m_regs[1]));
      check("bus_conflict", 32'(bus_conflict), 32'(m_conf));
      check("out_overflow", 32'(out_overflow), 32'(m_ovf));
    end
    @(posedge clk);
    model_step(inc, rw, en, bus, rdy, rstn);
  endtask

  task automatic idle(input logic rdy);
    drive(8'h00, 8'h00, 8'h00, 8'h00, rdy, 1'b1);
  endtask

  // Monitor: compares queue output against the scoreboard and retires accepted items.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (started) begin
        check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
        if (out_valid) begin
          if (exp_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL out_data: got %0h expected no entry at %0t", out_data, $time);
          end else begin
            check("out_data", 32'(out_data), 32'(exp_q[0]));
            if (out_ready && rst) void'(exp_q.pop_front());
          end
        end else if (last_rst) begin
          check("out_data_reset", 32'(out_data), 32'h0);
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
    drive(8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    drive(8'hFF, 8'h00, 8'hFF, 8'h33, 1'b1, 1'b0);
    started = 1;
    idle(1'b0);
    // Write then read reg 2.
    drive(8'h00, 8'h00, 8'h04, 8'h5A, 1'b0, 1'b1);
    drive(8'h00, 8'h04, 8'h04, 8'h00, 1'b0, 1'b1);
    // Increment wrap on reg 0, then ignored increment while reading.
    drive(8'h00, 8'h00, 8'h01, 8'hFF, 1'b0, 1'b1);
    drive(8'h01, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
    idle(1'b0);
    drive(8'h00, 8'h00, 8'h01, 8'hFF, 1'b0, 1'b1);
    drive(8'h01, 8'h01, 8'h01, 8'h00, 1'b0, 1'b1);
    drive(8'h01, 8'h01, 8'h00, 8'h00, 1'b0, 1'b1);
    idle(1'b0);
    // MOV: write reg 0 while reading reg 3.
    drive(8'h00, 8'h00, 8'h08, 8'h3C, 1'b0, 1'b1);
    drive(8'h00, 8'h08, 8'h09, 8'h3C, 1'b0, 1'b1);
    // Two readers -> conflict, sticky until reset.
    drive(8'h00, 8'h00, 8'h02, 8'h11, 1'b0, 1'b1);
    drive(8'h00, 8'h00, 8'h10, 8'h44, 1'b0, 1'b1);
    drive(8'h00, 8'h12, 8'h12, 8'h00, 1'b0, 1'b1);
    idle(1'b0);
    idle(1'b0);
    drive(8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    idle(1'b0);
    // Fill past capacity, then drain.
    for (int v = 1; v <= 5; v++) drive(8'h00, 8'h00, 8'h80, 8'(v), 1'b0, 1'b1);
    for (int k = 0; k < 6; k++) idle(1'b1);
    // Single write with ready held; then push+pop while full.
    drive(8'h00, 8'h00, 8'h80, 8'h07, 1'b1, 1'b1);
    idle(1'b1);
    idle(1'b1);
    for (int k = 0; k < DEPTH; k++) drive(8'h00, 8'h00, 8'h80, 8'(8'h20 + k), 1'b0, 1'b1);
    drive(8'h00, 8'h00, 8'h80, 8'h30, 1'b1, 1'b1);
    idle(1'b0);
    idle(1'b0);
    drive(8'h80, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
    for (int k = 0; k < DEPTH + 2; k++) idle(1'b1);
    // Reset discards queued entries and the concurrent reg 7 write.
    drive(8'h00, 8'h00, 8'h80, 8'h41, 1'b0, 1'b1);
    drive(8'h00, 8'h00, 8'h80, 8'h42, 1'b0, 1'b1);
    drive(8'h00, 8'h00, 8'h80, 8'h99, 1'b1, 1'b0);
    idle(1'b1);
    drive(8'h00, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1);
    // Random traffic.
    for (int k = 0; k < 3000; k++) begin
      logic [7:0] ri, rr, re, rb;
      ri = 8'($urandom);
      rr = 8'($urandom) & 8'($urandom);
      re = 8'($urandom) & 8'($urandom) & 8'($urandom);
      rb = 8'($urandom);
      drive(ri, rr, re, rb, 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 63) != 0));
    end
    for (int k = 0; k < DEPTH + 2; k++) idle(1'b1);
    @(negedge clk);
    #3;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
